// File: rtl/control_sequencer_pkg.sv
// Shared types for the hardwired control sequencer: opcodes, step encoding, instruction classes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package control_sequencer_pkg;

    localparam int OP_W = 5;
    typedef logic [OP_W-1:0] op_t;

    localparam op_t OP_LD   = 5'b00000;
    localparam op_t OP_LDI  = 5'b00001;
    localparam op_t OP_ST   = 5'b00010;
    localparam op_t OP_ADD  = 5'b00011;
    localparam op_t OP_SHL  = 5'b01011;
    localparam op_t OP_ADDI = 5'b01100;
    localparam op_t OP_ANDI = 5'b01101;
    localparam op_t OP_ORI  = 5'b01110;
    localparam op_t OP_MUL  = 5'b01111;
    localparam op_t OP_DIV  = 5'b10000;
    localparam op_t OP_NEG  = 5'b10001;
    localparam op_t OP_NOT  = 5'b10010;
    localparam op_t OP_BR   = 5'b10011;
    localparam op_t OP_JR   = 5'b10100;
    localparam op_t OP_JAL  = 5'b10101;
    localparam op_t OP_IN   = 5'b10110;
    localparam op_t OP_OUT  = 5'b10111;
    localparam op_t OP_MFHI = 5'b11000;
    localparam op_t OP_MFLO = 5'b11001;
    localparam op_t OP_NOP  = 5'b11010;
    localparam op_t OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        ST_RESET, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
    } step_t;

    // addi is split from andi/ori because only addi forces the ALU to ADD
    typedef enum logic [4:0] {
        CL_LD, CL_LDI, CL_ST, CL_ALU, CL_ADDI, CL_IMM, CL_MULDIV, CL_NEGNOT,
        CL_BR, CL_JR, CL_JAL, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_NOP, CL_HALT
    } iclass_t;

    typedef struct packed {
        logic ir_in;
        logic pc_in;
        logic ry_in;
        logic rz_in;
        logic mar_in;
        logic mdr_in;
        logic hi_in;
        logic lo_in;
        logic outport_in;
        logic hi_out;
        logic lo_out;
        logic zhi_out;
        logic zlo_out;
        logic pc_out;
        logic mdr_out;
        logic inport_out;
        logic c_out;
        logic gra;
        logic grb;
        logic grc;
        logic r_in;
        logic r_out;
        logic ba_out;
        logic con_in;
        logic mem_read;
        logic mem_write;
        logic inc_pc;
        logic op_add;
    } ctrl_t;

    function automatic iclass_t classify(input op_t op);
        iclass_t cl;
        case (op) inside
            OP_LD:             cl = CL_LD;
            OP_LDI:            cl = CL_LDI;
            OP_ST:             cl = CL_ST;
            [OP_ADD:OP_SHL]:   cl = CL_ALU;
            OP_ADDI:           cl = CL_ADDI;
            [OP_ANDI:OP_ORI]:  cl = CL_IMM;
            OP_MUL, OP_DIV:    cl = CL_MULDIV;
            OP_NEG, OP_NOT:    cl = CL_NEGNOT;
            OP_BR:             cl = CL_BR;
            OP_JR:             cl = CL_JR;
            OP_JAL:            cl = CL_JAL;
            OP_IN:             cl = CL_IN;
            OP_OUT:            cl = CL_OUT;
            OP_MFHI:           cl = CL_MFHI;
            OP_MFLO:           cl = CL_MFLO;
            OP_NOP:            cl = CL_NOP;
            OP_HALT:           cl = CL_HALT;
            default:           cl = CL_NOP;   // reserved opcodes behave as nop
        endcase
        return cl;
    endfunction

    // Steps that strobe the RAM and therefore stretch by the wait count
    function automatic logic is_mem_step(input step_t st, input iclass_t cl);
        return (st == ST_T1) || (st == ST_T6 && cl == CL_LD) || (st == ST_T7 && cl == CL_ST);
    endfunction

endpackage

// File: rtl/control_step_decode.sv
// Combinational decode of (step, instruction class, branch condition) into the datapath control word.
// Latency: zero cycles, pure function of registered step/class state.
// Backpressure: none; memory stretching is handled by the step FSM holding its state.
module control_step_decode
    import control_sequencer_pkg::*;
(
    input  step_t   state,
    input  iclass_t cls,
    input  logic    con_ff_bit,
    output ctrl_t   ctrl,
    output logic    run
);

    // One row per step; at most one bus source is raised in any row
    always_comb begin
        ctrl = '0;
        run  = 1'b1;
        case (state)
            ST_RESET, ST_HALT: run = 1'b0;
            ST_T0: begin
                ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1; ctrl.inc_pc = 1'b1; ctrl.rz_in = 1'b1;
            end
            ST_T1: begin
                ctrl.zlo_out = 1'b1; ctrl.pc_in = 1'b1; ctrl.mem_read = 1'b1; ctrl.mdr_in = 1'b1;
            end
            ST_T2: begin
                ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1;
            end
            ST_T3: begin
                case (cls)
                    CL_ALU, CL_ADDI, CL_IMM: begin ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.ry_in = 1'b1; end
                    CL_LD, CL_LDI, CL_ST:    begin ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.ry_in = 1'b1; end
                    CL_MULDIV: begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.ry_in = 1'b1; end
                    CL_NEGNOT: begin ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.rz_in = 1'b1; end
                    CL_BR:     begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.con_in = 1'b1; end
                    CL_JR:     begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.pc_in = 1'b1; end
                    // link register R15 is forced by the datapath when Grb selects under jal
                    CL_JAL:    begin ctrl.pc_out = 1'b1; ctrl.grb = 1'b1; ctrl.r_in = 1'b1; end
                    CL_IN:     begin ctrl.inport_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
                    CL_OUT:    begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.outport_in = 1'b1; end
                    CL_MFHI:   begin ctrl.hi_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
                    CL_MFLO:   begin ctrl.lo_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
                    default: ;
                endcase
            end
            ST_T4: begin
                case (cls)
                    CL_ALU:    begin ctrl.grc = 1'b1; ctrl.r_out = 1'b1; ctrl.rz_in = 1'b1; end
                    CL_IMM:    begin ctrl.c_out = 1'b1; ctrl.rz_in = 1'b1; end
                    CL_ADDI, CL_LD, CL_LDI, CL_ST: begin
                        ctrl.c_out = 1'b1; ctrl.rz_in = 1'b1; ctrl.op_add = 1'b1;
                    end
                    CL_MULDIV: begin ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.rz_in = 1'b1; end
                    CL_NEGNOT: begin ctrl.zlo_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
                    CL_BR:     begin ctrl.pc_out = 1'b1; ctrl.ry_in = 1'b1; end
                    CL_JAL:    begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.pc_in = 1'b1; end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (cls)
                    CL_ALU, CL_ADDI, CL_IMM, CL_LDI: begin
                        ctrl.zlo_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
                    end
                    CL_LD, CL_ST: begin ctrl.zlo_out = 1'b1; ctrl.mar_in = 1'b1; end
                    CL_MULDIV:    begin ctrl.zlo_out = 1'b1; ctrl.lo_in = 1'b1; end
                    CL_BR:        begin ctrl.c_out = 1'b1; ctrl.rz_in = 1'b1; ctrl.op_add = 1'b1; end
                    default: ;
                endcase
            end
            ST_T6: begin
                case (cls)
                    CL_LD:     begin ctrl.mem_read = 1'b1; ctrl.mdr_in = 1'b1; end
                    CL_ST:     begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.mdr_in = 1'b1; end
                    CL_MULDIV: begin ctrl.zhi_out = 1'b1; ctrl.hi_in = 1'b1; end
                    CL_BR: begin
                        ctrl.zlo_out = con_ff_bit;
                        ctrl.pc_in   = con_ff_bit;
                    end
                    default: ;
                endcase
            end
            ST_T7: begin
                case (cls)
                    CL_LD: begin ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
                    CL_ST: ctrl.mem_write = 1'b1;
                    default: ;
                endcase
            end
            default: run = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute step sequencer driving every datapath control line.
// Latency: one step per clock; memory steps held MEM_WAIT+1 clocks by a 3-bit wait counter.
// Backpressure: none from the datapath; stop halts at the next instruction boundary, clear restarts.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int MEM_WAIT = 1,
    parameter int OPCODE_W = 5
) (
    input  logic                clock,
    input  logic                clear,
    input  logic [31:0]         IR,
    input  logic                con_ff_bit,
    input  logic                stop,
    output logic                IRin,
    output logic                PCin,
    output logic                RYin,
    output logic                RZin,
    output logic                MARin,
    output logic                MDRin,
    output logic                HIin,
    output logic                LOin,
    output logic                Outport_in,
    output logic                HIout,
    output logic                LOout,
    output logic                Zhi_out,
    output logic                Zlo_out,
    output logic                PCout,
    output logic                MDRout,
    output logic                Inport_out,
    output logic                Cout,
    output logic                Gra,
    output logic                Grb,
    output logic                Grc,
    output logic                Rin,
    output logic                Rout,
    output logic                BAout,
    output logic                CONin,
    output logic                Mem_read,
    output logic                Mem_write,
    output logic                IncPC,
    output logic [OPCODE_W-1:0] opcode,
    output logic                run
);

    localparam logic [2:0] MEM_WAIT_CNT = 3'(MEM_WAIT);

    step_t   state;
    step_t   nxt;
    iclass_t class_q;
    iclass_t ir_class;
    iclass_t cls;
    logic [2:0] wait_cnt;
    logic    stop_req;
    ctrl_t   ctrl;
    logic    run_dec;
    op_t     op_sel;
    logic    ir_unused;

    // Only the opcode field steers sequencing; operand fields belong to the datapath
    assign ir_unused = ^IR[26:0];
    assign ir_class  = classify(IR[31:27]);
    // IR becomes valid at T3; the class is held from then on so later steps ignore IR
    assign cls = (state == ST_T3) ? ir_class : class_q;

    // Step successor ignoring memory waits and stop
    always_comb begin
        nxt = ST_RESET;
        case (state)
            ST_RESET: nxt = ST_T0;
            ST_T0:    nxt = ST_T1;
            ST_T1:    nxt = ST_T2;
            ST_T2:    nxt = ST_T3;
            ST_T3: begin
                case (cls)
                    CL_NOP, CL_JR, CL_IN, CL_OUT, CL_MFHI, CL_MFLO: nxt = ST_T0;
                    CL_HALT: nxt = ST_HALT;
                    default: nxt = ST_T4;
                endcase
            end
            ST_T4:    nxt = (cls == CL_NEGNOT || cls == CL_JAL) ? ST_T0 : ST_T5;
            ST_T5: begin
                case (cls)
                    CL_ALU, CL_ADDI, CL_IMM, CL_LDI: nxt = ST_T0;
                    default: nxt = ST_T6;
                endcase
            end
            ST_T6:    nxt = (cls == CL_MULDIV || cls == CL_BR) ? ST_T0 : ST_T7;
            ST_T7:    nxt = ST_T0;
            ST_HALT:  nxt = ST_HALT;
            default:  nxt = ST_RESET;
        endcase
    end

    // Step register, memory wait counter and sticky stop request
    always_ff @(posedge clock) begin
        if (clear) begin
            state    <= ST_RESET;
            wait_cnt <= 3'd0;
            class_q  <= CL_NOP;
            stop_req <= 1'b0;
        end else begin
            if (stop) begin
                stop_req <= 1'b1;
            end
            if (state == ST_T3) begin
                class_q <= ir_class;
            end
            if (is_mem_step(state, cls) && wait_cnt != 3'd0) begin
                wait_cnt <= wait_cnt - 3'd1;
            end else begin
                // a pending stop diverts the instruction-boundary fetch into HALT
                if (nxt == ST_T0 && (stop_req || stop)) begin
                    state <= ST_HALT;
                end else begin
                    state <= nxt;
                end
                wait_cnt <= is_mem_step(nxt, cls) ? MEM_WAIT_CNT : 3'd0;
            end
        end
    end

    control_step_decode u_decode (
        .state      (state),
        .cls        (cls),
        .con_ff_bit (con_ff_bit),
        .ctrl       (ctrl),
        .run        (run_dec)
    );

    assign op_sel = ctrl.op_add ? OP_ADD : IR[31:27];
    assign opcode = run_dec ? OPCODE_W'(op_sel) : '0;
    assign run    = run_dec;

    assign IRin       = ctrl.ir_in;
    assign PCin       = ctrl.pc_in;
    assign RYin       = ctrl.ry_in;
    assign RZin       = ctrl.rz_in;
    assign MARin      = ctrl.mar_in;
    assign MDRin      = ctrl.mdr_in;
    assign HIin       = ctrl.hi_in;
    assign LOin       = ctrl.lo_in;
    assign Outport_in = ctrl.outport_in;
    assign HIout      = ctrl.hi_out;
    assign LOout      = ctrl.lo_out;
    assign Zhi_out    = ctrl.zhi_out;
    assign Zlo_out    = ctrl.zlo_out;
    assign PCout      = ctrl.pc_out;
    assign MDRout     = ctrl.mdr_out;
    assign Inport_out = ctrl.inport_out;
    assign Cout       = ctrl.c_out;
    assign Gra        = ctrl.gra;
    assign Grb        = ctrl.grb;
    assign Grc        = ctrl.grc;
    assign Rin        = ctrl.r_in;
    assign Rout       = ctrl.r_out;
    assign BAout      = ctrl.ba_out;
    assign CONin      = ctrl.con_in;
    assign Mem_read   = ctrl.mem_read;
    assign Mem_write  = ctrl.mem_write;
    assign IncPC      = ctrl.inc_pc;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboarded bench for control_sequencer: per-cycle expected control words queued by stimulus.
// Latency: n/a.
// Backpressure: n/a.
module tb_control_sequencer;

    localparam int MW = 2;

    // bit positions of the observed control vector
    localparam logic [26:0] IRIN   = 27'd1 << 0;
    localparam logic [26:0] PCIN   = 27'd1 << 1;
    localparam logic [26:0] RYIN   = 27'd1 << 2;
    localparam logic [26:0] RZIN   = 27'd1 << 3;
    localparam logic [26:0] MARIN  = 27'd1 << 4;
    localparam logic [26:0] MDRIN  = 27'd1 << 5;
    localparam logic [26:0] HIIN   = 27'd1 << 6;
    localparam logic [26:0] LOIN   = 27'd1 << 7;
    localparam logic [26:0] OUTPIN = 27'd1 << 8;
    localparam logic [26:0] HIOUT  = 27'd1 << 9;
    localparam logic [26:0] LOOUT  = 27'd1 << 10;
    localparam logic [26:0] ZHIOUT = 27'd1 << 11;
    localparam logic [26:0] ZLOOUT = 27'd1 << 12;
    localparam logic [26:0] PCOUT  = 27'd1 << 13;
    localparam logic [26:0] MDROUT = 27'd1 << 14;
    localparam logic [26:0] INPOUT = 27'd1 << 15;
    localparam logic [26:0] COUT   = 27'd1 << 16;
    localparam logic [26:0] GRA    = 27'd1 << 17;
    localparam logic [26:0] GRB    = 27'd1 << 18;
    localparam logic [26:0] GRC    = 27'd1 << 19;
    localparam logic [26:0] RIN    = 27'd1 << 20;
    localparam logic [26:0] ROUT   = 27'd1 << 21;
    localparam logic [26:0] BAOUT  = 27'd1 << 22;
    localparam logic [26:0] CONIN  = 27'd1 << 23;
    localparam logic [26:0] MRD    = 27'd1 << 24;
    localparam logic [26:0] MWR    = 27'd1 << 25;
    localparam logic [26:0] INCPC  = 27'd1 << 26;
    localparam logic [26:0] BUS_M  = HIOUT | LOOUT | ZHIOUT | ZLOOUT | PCOUT | MDROUT |
                                     INPOUT | COUT | ROUT | BAOUT;

    typedef struct packed {
        logic [26:0] ctl;
        logic [4:0]  op;
        logic        run;
    } exp_t;

    logic        clock = 1'b0;
    logic        clear, con_ff_bit, stop;
    logic [31:0] IR;
    logic IRin, PCin, RYin, RZin, MARin, MDRin, HIin, LOin, Outport_in;
    logic HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout;
    logic Gra, Grb, Grc, Rin, Rout, BAout, CONin, Mem_read, Mem_write, IncPC, run;
    logic [4:0]  opcode;

    exp_t exp_q[$];
    exp_t steps[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clock = ~clock;

    control_sequencer #(.MEM_WAIT(MW), .OPCODE_W(5)) dut (
        .clock(clock), .clear(clear), .IR(IR), .con_ff_bit(con_ff_bit), .stop(stop),
        .IRin(IRin), .PCin(PCin), .RYin(RYin), .RZin(RZin), .MARin(MARin), .MDRin(MDRin),
        .HIin(HIin), .LOin(LOin), .Outport_in(Outport_in), .HIout(HIout), .LOout(LOout),
        .Zhi_out(Zhi_out), .Zlo_out(Zlo_out), .PCout(PCout), .MDRout(MDRout),
        .Inport_out(Inport_out), .Cout(Cout), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
        .Rout(Rout), .BAout(BAout), .CONin(CONin), .Mem_read(Mem_read), .Mem_write(Mem_write),
        .IncPC(IncPC), .opcode(opcode), .run(run)
    );

    // Monitor: one expected word per clock while the scoreboard holds entries
    always @(negedge clock) begin : monitor
        exp_t        e;
        logic [26:0] obs;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            obs = {IncPC, Mem_write, Mem_read, CONin, BAout, Rout, Rin, Grc, Grb, Gra, Cout,
                   Inport_out, MDRout, PCout, Zlo_out, Zhi_out, LOout, HIout, Outport_in,
                   LOin, HIin, MDRin, MARin, RZin, RYin, PCin, IRin};
            vectors++;
            if (obs !== e.ctl || opcode !== e.op || run !== e.run) begin
                miscompares++;
                $display("FAIL ctl_word[%0d] t=%0t: got ctl=%h op=%b run=%b, want ctl=%h op=%b run=%b",
                         vectors, $time, obs, opcode, run, e.ctl, e.op, e.run);
            end
            vectors++;
            if ($countones(obs & BUS_M) > 1) begin
                miscompares++;
                $display("FAIL bus_single_source[%0d]: got sources=%h, want at most one", vectors, obs & BUS_M);
            end
        end
    end

    function automatic exp_t idle_word();
        exp_t e;
        e.ctl = '0;
        e.op  = 5'd0;
        e.run = 1'b0;
        return e;
    endfunction

    function automatic void add_step(input logic [26:0] ctl, input bit use_add,
                                     input logic [4:0] op, input int reps);
        exp_t e;
        e.ctl = ctl;
        e.op  = use_add ? 5'd3 : op;
        e.run = 1'b1;
        for (int k = 0; k < reps; k++) steps.push_back(e);
    endfunction

    // Reference: the step table of each instruction group, memory steps repeated MW+1 times
    function automatic void build(input logic [4:0] op, input logic con);
        int o;
        o = int'(op);
        steps.delete();
        add_step(PCOUT | MARIN | INCPC | RZIN, 1'b0, op, 1);
        add_step(ZLOOUT | PCIN | MRD | MDRIN, 1'b0, op, MW + 1);
        add_step(MDROUT | IRIN, 1'b0, op, 1);
        if (o <= 2) begin
            add_step(GRB | BAOUT | RYIN, 1'b0, op, 1);
            add_step(COUT | RZIN, 1'b1, op, 1);
            if (o == 1) begin
                add_step(ZLOOUT | GRA | RIN, 1'b0, op, 1);
            end else begin
                add_step(ZLOOUT | MARIN, 1'b0, op, 1);
                if (o == 0) begin
                    add_step(MRD | MDRIN, 1'b0, op, MW + 1);
                    add_step(MDROUT | GRA | RIN, 1'b0, op, 1);
                end else begin
                    add_step(GRA | ROUT | MDRIN, 1'b0, op, 1);
                    add_step(MWR, 1'b0, op, MW + 1);
                end
            end
        end else if (o <= 11) begin
            add_step(GRB | ROUT | RYIN, 1'b0, op, 1);
            add_step(GRC | ROUT | RZIN, 1'b0, op, 1);
            add_step(ZLOOUT | GRA | RIN, 1'b0, op, 1);
        end else if (o <= 14) begin
            add_step(GRB | ROUT | RYIN, 1'b0, op, 1);
            add_step(COUT | RZIN, o == 12, op, 1);
            add_step(ZLOOUT | GRA | RIN, 1'b0, op, 1);
        end else if (o <= 16) begin
            add_step(GRA | ROUT | RYIN, 1'b0, op, 1);
            add_step(GRB | ROUT | RZIN, 1'b0, op, 1);
            add_step(ZLOOUT | LOIN, 1'b0, op, 1);
            add_step(ZHIOUT | HIIN, 1'b0, op, 1);
        end else if (o <= 18) begin
            add_step(GRB | ROUT | RZIN, 1'b0, op, 1);
            add_step(ZLOOUT | GRA | RIN, 1'b0, op, 1);
        end else if (o == 19) begin
            add_step(GRA | ROUT | CONIN, 1'b0, op, 1);
            add_step(PCOUT | RYIN, 1'b0, op, 1);
            add_step(COUT | RZIN, 1'b1, op, 1);
            add_step(con ? (ZLOOUT | PCIN) : 27'd0, 1'b0, op, 1);
        end else if (o == 20) add_step(GRA | ROUT | PCIN, 1'b0, op, 1);
        else if (o == 21) begin
            add_step(PCOUT | GRB | RIN, 1'b0, op, 1);
            add_step(GRA | ROUT | PCIN, 1'b0, op, 1);
        end
        else if (o == 22) add_step(INPOUT | GRA | RIN, 1'b0, op, 1);
        else if (o == 23) add_step(GRA | ROUT | OUTPIN, 1'b0, op, 1);
        else if (o == 24) add_step(HIOUT | GRA | RIN, 1'b0, op, 1);
        else if (o == 25) add_step(LOOUT | GRA | RIN, 1'b0, op, 1);
        else add_step(27'd0, 1'b0, op, 1);   // nop, halt and reserved: decode-only step
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic halt_then_clear(input int n);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(idle_word());
            tick();
        end
        clear = 1'b1;
        exp_q.push_back(idle_word());
        tick();
        clear = 1'b0;
        exp_q.push_back(idle_word());   // RESET cycle
        tick();
    endtask

    // Runs one instruction from T0; optional stop pulse or clear at a cycle index (-1 = none)
    task automatic run_instr(input logic [31:0] ir, input logic con,
                             input int stop_cyc, input int clear_cyc, input int hold);
        int n;
        IR = ir;
        con_ff_bit = con;
        build(ir[31:27], con);
        n = steps.size();
        if (stop_cyc >= n)  stop_cyc  = stop_cyc % n;
        if (clear_cyc >= n) clear_cyc = clear_cyc % n;
        for (int i = 0; i < n; i++) begin
            if (i == stop_cyc)  stop  = 1'b1;
            if (i == clear_cyc) clear = 1'b1;
            exp_q.push_back(steps[i]);
            tick();
            stop = 1'b0;
            if (i == clear_cyc) begin
                clear = 1'b0;
                exp_q.push_back(idle_word());
                tick();
                return;
            end
        end
        if (ir[31:27] == 5'd27 || stop_cyc >= 0) halt_then_clear(hold);
    endtask

    initial begin
        logic [4:0] rop;
        int mode;
        clear = 1'b1;
        stop = 1'b0;
        IR = 32'd0;
        con_ff_bit = 1'b0;
        tick();
        clear = 1'b0;
        exp_q.push_back(idle_word());
        tick();

        run_instr({5'b00011, 4'd3, 4'd1, 4'd2, 15'd0}, 1'b0, -1, -1, 0);   // add R3,R1,R2
        run_instr({5'b00000, 4'd1, 4'd0, 19'h54}, 1'b0, -1, -1, 0);        // ld R1,0x54(R0)
        run_instr({5'b10011, 4'd4, 4'd0, 19'd9}, 1'b1, -1, -1, 0);         // br taken
        run_instr({5'b10011, 4'd4, 4'd0, 19'd9}, 1'b0, -1, -1, 0);         // br not taken
        for (int o = 1; o <= 31; o++) begin
            if (o != 27 && o != 19) run_instr({5'(o), 27'h0123456}, 1'b1, -1, -1, 0);
        end
        run_instr({5'b00000, 4'd1, 4'd0, 19'h54}, 1'b0, -1, 9, 0);         // clear mid T6 wait
        run_instr({5'b00011, 4'd3, 4'd1, 4'd2, 15'd0}, 1'b0, 6, -1, 4);    // stop pulse in T4
        run_instr({5'b11011, 27'd0}, 1'b0, -1, -1, 20);                    // halt opcode

        for (int k = 0; k < 80; k++) begin
            rop  = 5'($urandom_range(0, 31));
            mode = $urandom_range(0, 9);
            run_instr({rop, 27'($urandom)}, 1'($urandom_range(0, 1)),
                      (mode == 0) ? $urandom_range(0, 99) : -1,
                      (mode == 1) ? $urandom_range(0, 99) : -1,
                      $urandom_range(1, 5));
        end

        @(negedge clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
